// File: rtl/delay_line_prog_if.sv
// Sample/control bundle for the programmable delay line.
// The master side drives the sample stream and delay control.
// The slave side (the delay line) returns the delayed sample and its status.
interface delay_line_prog_if #(
  parameter int DW        = 16,
  parameter int MAX_DEPTH = 64
);
  localparam int DLYW = $clog2(MAX_DEPTH + 1);

  logic            i_en;
  logic [DW-1:0]   i_xin;
  logic            i_clr;
  logic            i_dly_ld;
  logic [DLYW-1:0] i_dly;
  logic [DW-1:0]   o_xin_delay;
  logic            o_valid_out;
  logic            o_filled;
  logic [DLYW-1:0] o_cur_dly;

  modport master (
    output i_en, i_xin, i_clr, i_dly_ld, i_dly,
    input  o_xin_delay, o_valid_out, o_filled, o_cur_dly
  );

  modport slave (
    input  i_en, i_xin, i_clr, i_dly_ld, i_dly,
    output o_xin_delay, o_valid_out, o_filled, o_cur_dly
  );
endinterface

// File: rtl/delay_line_prog.sv
// Programmable-depth sample delay line.
// A circular buffer holds the last MAX_DEPTH accepted samples. Each accepted
// sample is written at wp, and the entry written D accepted samples earlier is
// read at the same time. Output is suppressed until D samples have arrived
// since reset, flush or delay reload.
module delay_line_prog #(
  parameter int DW          = 16,
  parameter int MAX_DEPTH   = 64,
  parameter int DEFAULT_DLY = 30
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  delay_line_prog_if.slave   bus
);
  localparam int DLYW = $clog2(MAX_DEPTH + 1);
  localparam int AW   = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  // Sample storage. It is never reset: its contents are not visible until a
  // full refill has overwritten every entry that can be read.
  logic [DW-1:0]   r_mem [MAX_DEPTH];

  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   w_wp_next;
  logic [AW-1:0]   w_wp_inc;
  logic [AW-1:0]   w_rd_addr;
  logic [DLYW:0]   w_rd_calc;
  logic [DLYW-1:0] r_dly;
  logic [DLYW-1:0] w_dly_next;
  logic [DLYW-1:0] w_dly_clamp;
  logic [DLYW-1:0] r_fc;
  logic [DLYW-1:0] w_fc_next;
  logic [DW-1:0]   r_xd;
  logic [DW-1:0]   w_xd_next;
  logic [DW-1:0]   w_rd_data;
  logic            r_valid;
  logic            w_valid_next;
  logic            r_filled;
  logic            w_filled_next;
  logic            w_wr_en;

  // Write pointer increment with wrap at MAX_DEPTH-1 (depth need not be 2^n).
  always_comb begin
    w_wp_inc = r_wp + AW'(1);
    if (r_wp == AW'(MAX_DEPTH - 1)) begin
      w_wp_inc = '0;
    end
  end

  // Read address (wp - D) mod MAX_DEPTH. With D = MAX_DEPTH this is wp itself,
  // i.e. the entry about to be overwritten, which is read before the write.
  always_comb begin
    w_rd_calc = (DLYW+1)'(r_wp) + (DLYW+1)'(MAX_DEPTH) - (DLYW+1)'(r_dly);
    if (w_rd_calc >= (DLYW+1)'(MAX_DEPTH)) begin
      w_rd_calc = w_rd_calc - (DLYW+1)'(MAX_DEPTH);
    end
    w_rd_addr = AW'(w_rd_calc);
  end

  assign w_rd_data = r_mem[w_rd_addr];

  // Requested delay clamped into the supported range 1..MAX_DEPTH.
  always_comb begin
    w_dly_clamp = bus.i_dly;
    if (bus.i_dly == '0) begin
      w_dly_clamp = DLYW'(1);
    end else if (bus.i_dly > DLYW'(MAX_DEPTH)) begin
      w_dly_clamp = DLYW'(MAX_DEPTH);
    end
  end

  // A flushed cycle discards its sample; otherwise every EN sample is stored.
  assign w_wr_en = bus.i_en && !bus.i_clr;

  // Next-state selection with priority flush > delay load > sample accept.
  always_comb begin
    w_wp_next     = r_wp;
    w_dly_next    = r_dly;
    w_fc_next     = r_fc;
    w_xd_next     = r_xd;
    w_valid_next  = 1'b0;
    if (bus.i_clr) begin
      w_wp_next = '0;
      w_fc_next = '0;
      w_xd_next = '0;
      if (bus.i_dly_ld) begin
        w_dly_next = w_dly_clamp;
      end
    end else if (bus.i_dly_ld) begin
      // The reload keeps the buffer; a concurrent sample starts the refill.
      w_dly_next = w_dly_clamp;
      if (bus.i_en) begin
        w_wp_next = w_wp_inc;
        w_fc_next = DLYW'(1);
      end else begin
        w_fc_next = '0;
      end
    end else if (bus.i_en) begin
      w_wp_next = w_wp_inc;
      if (r_fc == r_dly) begin
        w_xd_next    = w_rd_data;
        w_valid_next = 1'b1;
      end else begin
        w_fc_next = r_fc + DLYW'(1);
      end
    end
    w_filled_next = (w_fc_next == w_dly_next);
  end

  // Control and output registers, cleared asynchronously on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp     <= '0;
      r_dly    <= DLYW'(DEFAULT_DLY);
      r_fc     <= '0;
      r_xd     <= '0;
      r_valid  <= 1'b0;
      r_filled <= 1'b0;
    end else begin
      r_wp     <= w_wp_next;
      r_dly    <= w_dly_next;
      r_fc     <= w_fc_next;
      r_xd     <= w_xd_next;
      r_valid  <= w_valid_next;
      r_filled <= w_filled_next;
    end
  end

  // Buffer write; the read above sees the old contents on the same edge.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wp] <= bus.i_xin;
    end
  end

  assign bus.o_xin_delay = r_xd;
  assign bus.o_valid_out = r_valid;
  assign bus.o_filled    = r_filled;
  assign bus.o_cur_dly   = r_dly;
endmodule

// File: tb/tb_delay_line_prog.sv
// Directed-plus-random bench for delay_line_prog against a queue-based model.
module tb_delay_line_prog;
  localparam int DW   = 16;
  localparam int MAXD = 64;
  localparam int DLYW = $clog2(MAXD + 1);

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  // Reference model state: accepted samples since last flush/reset, the
  // delay in effect, samples accepted since the last refill started.
  logic [DW-1:0] hist[$];
  int            m_d;
  int            m_fc;
  logic [DW-1:0] m_xd;
  logic          m_valid;
  int            n_acc;

  delay_line_prog_if #(.DW(DW), .MAX_DEPTH(MAXD)) bus ();

  delay_line_prog #(.DW(DW), .MAX_DEPTH(MAXD), .DEFAULT_DLY(30)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampd(input int v);
    if (v == 0) return 1;
    if (v > MAXD) return MAXD;
    return v;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_d = 30; m_fc = 0; m_xd = '0; m_valid = 1'b0;
  endtask

  // Apply the rules of one clock edge to the model.
  task automatic model_edge(input logic en, input logic [DW-1:0] x,
                            input logic clr, input logic ld, input int dly);
    m_valid = 1'b0;
    if (clr) begin
      hist.delete(); m_fc = 0; m_xd = '0;
      if (ld) m_d = clampd(dly);
    end else if (ld) begin
      m_d = clampd(dly);
      m_fc = en ? 1 : 0;
      if (en) hist.push_back(x);
    end else if (en) begin
      if (m_fc == m_d) begin
        m_xd = hist[hist.size() - m_d];
        m_valid = 1'b1;
      end else begin
        m_fc++;
      end
      hist.push_back(x);
    end
    while (hist.size() > 4 * MAXD) void'(hist.pop_front());
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_xd"},     32'(bus.o_xin_delay), 32'(m_xd));
    chk({tag, "_valid"},  32'(bus.o_valid_out), 32'(m_valid));
    chk({tag, "_filled"}, 32'(bus.o_filled),    32'(m_fc == m_d));
    chk({tag, "_dly"},    32'(bus.o_cur_dly),   32'(m_d));
  endtask

  // One clock: drive at the falling edge, check 1 time unit after the rise.
  task automatic tick(input logic en, input logic [DW-1:0] x, input logic clr,
                      input logic ld, input int dly, input string tag);
    @(negedge clk);
    bus.i_en = en; bus.i_xin = x; bus.i_clr = clr; bus.i_dly_ld = ld;
    bus.i_dly = DLYW'(dly);
    @(posedge clk);
    model_edge(en, x, clr, ld, dly);
    if (en && !clr) n_acc++;
    #1;
    check_all(tag);
    $display("t=%0t %s en=%0d x=%h clr=%0d ld=%0d -> xd=%h v=%0d f=%0d d=%0d", $time, tag,
             en, x, clr, ld, bus.o_xin_delay, bus.o_valid_out, bus.o_filled, bus.o_cur_dly);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_acc = 0;
    bus.i_en = 1'b0; bus.i_xin = '0; bus.i_clr = 1'b0; bus.i_dly_ld = 1'b0; bus.i_dly = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous stream 1,2,3,... at the default delay of 30.
    for (int k = 1; k <= 40; k++) begin
      tick(1'b1, DW'(k), 1'b0, 1'b0, 0, "stream");
      if (k == 29) chk("filled_before_30", 32'(bus.o_filled), 32'd0);
      if (k == 30) chk("filled_at_30", 32'(bus.o_filled), 32'd1);
      if (k == 30) chk("no_valid_at_30", 32'(bus.o_valid_out), 32'd0);
      if (k == 31) chk("first_out_valid", 32'(bus.o_valid_out), 32'd1);
      if (k == 31) chk("first_out_value", 32'(bus.o_xin_delay), 32'd1);
    end

    // EN toggling: output only after EN edges.
    for (int n = 0; n < 60; n++) begin
      tick(n[0] == 1'b0, DW'(16'hA000 + n), 1'b0, 1'b0, 0, "toggle");
    end

    // Reload to D=5 mid-stream, then random EN.
    tick(1'b1, DW'(16'hB000), 1'b0, 1'b1, 5, "ld5");
    chk("ld5_curdly", 32'(bus.o_cur_dly), 32'd5);
    for (int n = 1; n <= 30; n++) begin
      tick(1'($urandom_range(0, 3) != 0), DW'(16'hB000 + n), 1'b0, 1'b0, 0, "d5");
    end

    // Clamp boundaries.
    tick(1'b0, '0, 1'b0, 1'b1, 0, "ld0");
    chk("clamp_low", 32'(bus.o_cur_dly), 32'd1);
    for (int n = 0; n < 5; n++) tick(1'b1, DW'($urandom), 1'b0, 1'b0, 0, "d1");
    tick(1'b0, '0, 1'b0, 1'b1, 100, "ld100");
    chk("clamp_high", 32'(bus.o_cur_dly), 32'd64);

    // Full depth across several pointer wraps.
    for (int n = 0; n < 300; n++) tick(1'b1, DW'($urandom), 1'b0, 1'b0, 0, "d64");

    // Flush together with a sample that must never emerge.
    tick(1'b1, DW'(16'h1234), 1'b1, 1'b0, 0, "clr");
    chk("clr_xd_zero", 32'(bus.o_xin_delay), 32'd0);
    for (int n = 0; n < 90; n++) begin
      tick(1'b1, DW'($urandom_range(1, 16'h0FFF)), 1'b0, 1'b0, 0, "refill");
      chk("no_1234", 32'(bus.o_xin_delay == DW'(16'h1234)), 32'd0);
    end

    // Back to 30, then random control mix.
    tick(1'b1, DW'($urandom), 1'b0, 1'b1, 30, "ld30");
    for (int n = 0; n < 400; n++) begin
      tick(1'($urandom_range(0, 4) != 0), DW'($urandom), 1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 79) == 0), int'($urandom_range(0, 127)), "rand");
    end
    tick(1'b1, DW'(7), 1'b0, 1'b1, 30, "ld30b");
    for (int n = 0; n < 35; n++) tick(1'b1, DW'(n + 100), 1'b0, 1'b0, 0, "pre_rst");

    // Asynchronous reset pulse between edges.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    rst_n = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      tick(1'b1, DW'(16'hC000 + k), 1'b0, 1'b0, 0, "post_rst");
      if (k == 31) chk("post_rst_first", 32'(bus.o_xin_delay), 32'hC001);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/delay_line_prog.md
# delay_line_prog

Parametrised, programmable-depth sample delay line for the EMD datapath; successor to the fixed 16-bit, 30-sample shift delay. Aligns a sample stream with a slower parallel path (envelope/extrema processing) by delaying it a runtime-selected number of *accepted* samples. Adds per-sample enable, runtime delay load, synchronous flush, and fill/valid status that the fixed block lacks.

## Interface
- DW, 16, sample width (bits)
- MAX_DEPTH, 64, largest supported delay in samples (≥2)
- DEFAULT_DLY, 30, delay after reset (1..MAX_DEPTH)
- DLYW, clog2(MAX_DEPTH+1), width of DLY port (derived, not overridden)

- CLK  in  1  rising-edge clock; the block's only clock
- RST_N  in  1  asynchronous, active-low reset
- EN  in  1  Xin is valid this cycle; only EN cycles advance the line
- Xin  in  DW  input sample
- CLR  in  1  synchronous flush
- DLY_LD  in  1  load DLY as the new delay
- DLY  in  DLYW  requested delay in samples
- Xin_DELAY  out  DW  delayed sample, registered
- VALID_OUT  out  1  one-cycle pulse: Xin_DELAY updated with a real sample
- FILLED  out  1  line holds ≥ current delay samples
- CUR_DLY  out  DLYW  delay in effect

## Operation
- Storage: MAX_DEPTH×DW circular buffer, write pointer wp (wraps MAX_DEPTH-1→0), fill counter fc saturating at current delay D.
- EN cycle: buffer[wp] ← Xin; wp advances. Read address (wp − D) mod MAX_DEPTH, read-before-write, so D = MAX_DEPTH returns the entry being overwritten.
- If fc = D before the edge: Xin_DELAY ← sample accepted D EN-cycles earlier, VALID_OUT pulses. Else fc increments, Xin_DELAY unchanged, VALID_OUT low.
- Non-EN cycle: no state changes except VALID_OUT ← 0.
- DLY_LD: D ← clamp(DLY): 0 → 1, > MAX_DEPTH → MAX_DEPTH. fc ← 0, FILLED ← 0. Buffer contents and wp are kept, but the output is suppressed until D new samples have arrived. Any EN sample in the same cycle is written, counts as first of the refill, and produces no output.
- CLR: wp ← 0, fc ← 0, Xin_DELAY ← 0, VALID_OUT ← 0, FILLED ← 0. D is kept. Any EN sample in the same cycle is discarded.
- Priority in the same cycle: CLR > DLY_LD > EN. With CLR and DLY_LD together, both take effect.
- FILLED = (fc == D), registered.
- Reset (RST_N low, async): Xin_DELAY = 0, VALID_OUT = 0, FILLED = 0, CUR_DLY = DEFAULT_DLY, wp = 0, fc = 0. Buffer contents are don't-care because they are never output before refill.

## Timing
- Latency: the sample accepted on the k-th EN edge appears on Xin_DELAY after the (k+D)-th EN edge, with VALID_OUT high the cycle after that edge.
- With EN held high continuously, the delay is exactly D clocks.
- Throughput: one sample per clock. There is no backpressure.
- CUR_DLY and FILLED update on the edge that applies DLY_LD or CLR.
- A reset mid-stream drops all in-flight samples. The first valid output comes D EN-cycles after RST_N deasserts.
- Reset deassertion is synchronised externally; the block only requires RST_N to be async-assertable.

## Test plan
- Reset, DEFAULT_DLY=30, EN=1, Xin = 1,2,3,… → VALID_OUT first high the cycle after the 31st edge with Xin_DELAY=1, then 2,3,… every clock. FILLED rises on the 30th edge.
- EN toggling 1,0,1,0 with Xin = 0xA000+n → output sequence unchanged, and VALID_OUT pulses only after EN edges once filled.
- DLY_LD with DLY=5 mid-stream at sample 100 → VALID_OUT low for 5 EN cycles, then Xin_DELAY = sample (k−5). DLY=0 gives CUR_DLY=1. DLY=200 gives CUR_DLY=64.
- D=MAX_DEPTH=64, run 300 samples → exact 64-sample delay across wp wrap-around, with no corruption at index 63→0.
- CLR asserted together with EN and Xin=0x1234 → outputs zero, 0x1234 never emerges, and the refill takes D samples.
- RST_N pulsed low asynchronously (between edges) mid-stream → outputs zero immediately, CUR_DLY=30, and the first post-reset output is the first post-reset sample.
